// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-lane dual-port data memory.
//   size_e      : access size encoding (byte / half / word / illegal)
//   WORD_BYTES  : bytes per memory word
//   gen_strobe  : byte-lane write strobe for a size and lane offset
//   load_extend : lane extract plus sign/zero extension of a load word
package dmem_pkg;

  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_X = 2'd3
  } size_e;

  function automatic logic [WORD_BYTES-1:0] gen_strobe(input size_e size, input logic [1:0] lane);
    case (size)
      SZ_B:    gen_strobe = 4'b0001 << lane;
      SZ_H:    gen_strobe = 4'b0011 << lane;
      SZ_W:    gen_strobe = 4'b1111;
      default: gen_strobe = '0;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input size_e size,
                                              input logic [1:0] lane, input logic zext);
    logic [31:0] sh;
    sh = word >> {lane, 3'b000};
    case (size)
      SZ_B:    load_extend = zext ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      SZ_H:    load_extend = zext ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: load_extend = sh;  // word accesses are aligned, so sh == word
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_ctl.sv
// Per-port request decode for dmem_dp_bytelane (purely combinational).
//   size, zext, addr, wdata : request fields from the port
//   rword                   : raw 32-bit word read at idx
//   err   : illegal size, misaligned access or address beyond DEPTH words
//   strb  : byte-lane write strobes
//   idx   : word index into the array
//   wlanes: store data replicated onto every lane (strb selects the live one)
//   rdata : load result, lane-extracted and sign/zero-extended
module dmem_lane_ctl
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 32
) (
  input  logic [1:0]               size,
  input  logic                     zext,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [31:0]              wdata,
  input  logic [31:0]              rword,
  output logic                     err,
  output logic [3:0]               strb,
  output logic [$clog2(DEPTH)-1:0] idx,
  output logic [31:0]              wlanes,
  output logic [31:0]              rdata
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  size_e      sz;
  logic [1:0] lane;
  logic       misalign;
  logic       out_of_range;

  assign sz   = size_e'(size);
  assign lane = addr[1:0];
  assign idx  = addr[IDX_W+1:2];

  always_comb begin
    misalign = 1'b0;
    case (sz)
      SZ_H:    misalign = addr[0];
      SZ_W:    misalign = (addr[1:0] != 2'b00);
      SZ_X:    misalign = 1'b1;
      default: misalign = 1'b0;
    endcase
  end

  assign out_of_range = |addr[ADDR_W-1:IDX_W+2];
  assign err          = misalign | out_of_range;
  assign strb         = gen_strobe(sz, lane);

  always_comb begin
    case (sz)
      SZ_B:    wlanes = {4{wdata[7:0]}};
      SZ_H:    wlanes = {2{wdata[15:0]}};
      default: wlanes = wdata;
    endcase
  end

  assign rdata = load_extend(rword, sz, lane, zext);

endmodule

// File: rtl/dmem_dp_bytelane.sv
// Dual-port byte-lane data memory for the RV32IF core.
//   Port A: integer loads/stores, port B: FLW/FSW. Byte addresses, byte-lane
//   strobes, registered 1-cycle read latency, per-byte A-priority write merge.
// Ports:
//   clk, rst_n (async active-low)
//   x_en, x_we, x_size, x_unsigned, x_addr, x_wdata : request (x = a, b)
//   x_rvalid, x_rdata, x_err                        : 1-cycle response
//   wconflict : both ports wrote a common byte on the previous edge
// Build option:
//   DMEM_WFWD_EN : a load returns the merged post-write word when the other
//                  port stores to the same word in the same cycle; otherwise
//                  the load sees the pre-write contents (read-first).
module dmem_dp_bytelane
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_en,
  input  logic              a_we,
  input  logic [1:0]        a_size,
  input  logic              a_unsigned,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [31:0]       a_wdata,
  input  logic              b_en,
  input  logic              b_we,
  input  logic [1:0]        b_size,
  input  logic              b_unsigned,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [31:0]       b_wdata,
  output logic              a_rvalid,
  output logic [31:0]       a_rdata,
  output logic              a_err,
  output logic              b_rvalid,
  output logic [31:0]       b_rdata,
  output logic              b_err,
  output logic              wconflict
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [3:0][7:0] mem [DEPTH];

  logic [IDX_W-1:0] a_idx, b_idx;
  logic [3:0]       a_strb, b_strb;
  logic [31:0]      a_wl, b_wl, a_rword, b_rword, a_ext, b_ext;
  logic             a_bad, b_bad;

  dmem_lane_ctl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_lane_a (
    .size(a_size), .zext(a_unsigned), .addr(a_addr), .wdata(a_wdata), .rword(a_rword),
    .err(a_bad), .strb(a_strb), .idx(a_idx), .wlanes(a_wl), .rdata(a_ext)
  );

  dmem_lane_ctl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_lane_b (
    .size(b_size), .zext(b_unsigned), .addr(b_addr), .wdata(b_wdata), .rword(b_rword),
    .err(b_bad), .strb(b_strb), .idx(b_idx), .wlanes(b_wl), .rdata(b_ext)
  );

  logic       a_wr, b_wr, a_ld, b_ld, same_word;
  logic [3:0] a_wmask, b_wreq, b_wmask;

  assign a_wr      = a_en & a_we & ~a_bad;
  assign b_wr      = b_en & b_we & ~b_bad;
  assign a_ld      = a_en & ~a_we & ~a_bad;
  assign b_ld      = b_en & ~b_we & ~b_bad;
  assign same_word = (a_idx == b_idx);

  assign a_wmask = a_wr ? a_strb : '0;
  assign b_wreq  = b_wr ? b_strb : '0;
  // B loses only the bytes A also writes in the same word
  assign b_wmask = b_wreq & ~(same_word ? a_wmask : 4'b0000);

  // Array is never reset; stores are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int unsigned i = 0; i < WORD_BYTES; i++) begin
        if (a_wmask[i]) mem[a_idx][i] <= a_wl[8*i +: 8];
        if (b_wmask[i]) mem[b_idx][i] <= b_wl[8*i +: 8];
      end
    end
  end

  always_comb begin
    a_rword = mem[a_idx];
    b_rword = mem[b_idx];
`ifdef DMEM_WFWD_EN
    // Only the other port's store can hit: the loading port itself does not write.
    for (int unsigned i = 0; i < WORD_BYTES; i++) begin
      if (b_wmask[i] && same_word) a_rword[8*i +: 8] = b_wl[8*i +: 8];
      if (a_wmask[i] && same_word) b_rword[8*i +: 8] = a_wl[8*i +: 8];
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rvalid  <= 1'b0;
      a_rdata   <= '0;
      a_err     <= 1'b0;
      b_rvalid  <= 1'b0;
      b_rdata   <= '0;
      b_err     <= 1'b0;
      wconflict <= 1'b0;
    end else begin
      a_rvalid  <= a_ld;
      a_rdata   <= a_ld ? a_ext : '0;
      a_err     <= a_en & a_bad;
      b_rvalid  <= b_ld;
      b_rdata   <= b_ld ? b_ext : '0;
      b_err     <= b_en & b_bad;
      wconflict <= same_word & |(a_wmask & b_wreq);
    end
  end

endmodule

// File: doc/dmem_dp_bytelane.md
# dmem_dp_bytelane

Parametrised dual-port data memory for the RV32IF core, the successor to the current word-only dual-port data memory. Port A serves integer loads/stores (LB/LH/LW/LBU/LHU/SB/SH/SW), port B serves FLW/FSW. Both ports take byte addresses and use byte-lane strobes. Each port has registered 1-cycle read latency, alignment and range checking, and per-byte write-conflict resolution with port A priority.

## Interface
Parameters:
- DEPTH, 256: number of 32-bit words; power of two, at least 4.
- ADDR_W, 32: byte-address width.

Ports:
- clk, in, 1: single clock; all state updates on the rising edge.
- rst_n, in, 1: reset, asynchronous, active-low.
- a_en, b_en, in, 1: request valid for port A / B, sampled each posedge.
- a_we, b_we, in, 1: 1 = store, 0 = load.
- a_size, b_size, in, 2: access size; 0 = byte, 1 = half, 2 = word, 3 = illegal.
- a_unsigned, b_unsigned, in, 1: zero-extend loads (LBU/LHU); ignored for words and stores.
- a_addr, b_addr, in, ADDR_W: byte address.
- a_wdata, b_wdata, in, 32: store data, right-justified; lane replication is done internally.
- a_rvalid, b_rvalid, out, 1: load data valid, 1-cycle pulse.
- a_rdata, b_rdata, out, 32: sign- or zero-extended load result.
- a_err, b_err, out, 1: request rejected, 1-cycle pulse.
- wconflict, out, 1: both ports wrote at least one common byte in the previous cycle, 1-cycle pulse.

## Operation
- Word index = addr[log2(DEPTH)+1:2]. Lane = addr[1:0].
- Error conditions, any one sets err:
  - size == 3;
  - half access with addr[0] == 1;
  - word access with addr[1:0] != 0;
  - addr[ADDR_W-1:log2(DEPTH)+2] != 0.
- An errored request does not write. On an errored request rvalid = 0 and rdata = 0.
- Strobes:
  - byte: 1 << lane.
  - half: 2'b11 << lane.
  - word: 4'hF.
- Store data is shifted to lane position: byte = wdata[7:0] in the strobed lane; half = wdata[15:0].
- Loads select the addressed lane and sign-extend from bit 7 or 15, or zero-extend when x_unsigned = 1.
- Conflict: both ports store to the same word in the same cycle.
  - Overlapping bytes take port A data.
  - Non-overlapping strobed bytes of port B are still written.
  - wconflict = 1 only if the strobes overlap.
- Read-during-write on the same word by the other port: the load returns the pre-write contents (read-first).
- Memory contents are not reset and start undefined.

## Timing
- Request sampled at posedge N. Store commits at posedge N. rvalid/rdata/err/wconflict are valid after posedge N+1 for exactly one cycle.
- No back-pressure: a new request may be issued every cycle on each port, full throughput.
- Stores never assert rvalid. Error-free stores produce no response.
- Reset values: a_rvalid = b_rvalid = 0, a_rdata = b_rdata = 0, a_err = b_err = 0, wconflict = 0.
- Reset asserted mid-operation: pending responses are dropped and outputs go to 0 immediately. A store sampled in the same edge that reset is released is ignored. Memory contents are kept.
- rdata is held at 0 in any cycle without rvalid.

## Configuration
- DMEM_WFWD_EN defined: a load on one port to the word the other port stores in the same cycle returns merged post-write data, using the same per-byte A-priority merge. Latency is unchanged.
- DMEM_WFWD_EN undefined: read-first behaviour as described in Operation.

## Structure
- Package dmem_pkg:
  - size encodings SZ_B, SZ_H, SZ_W;
  - function for strobe generation;
  - function for load extension;
  - constant WORD_BYTES = 4.
- Sub-module dmem_lane_ctl, one instance per port, combinational:
  - alignment and range check;
  - strobe generation;
  - store lane shift;
  - load extract and extend.
- The top level holds the memory array, the conflict merge and the response registers.

## Test plan
- Reset: hold rst_n = 0 with both ports issuing loads -> all outputs 0. Release, then A store size=2 addr=0x10 wdata=0xDEADBEEF, then A load addr=0x10 -> rvalid one cycle later, rdata = 0xDEADBEEF.
- Byte and half extension: word at 0x20 = 0x80FF7F01.
  - LB addr=0x23 -> 0xFFFFFF80.
  - LBU addr=0x23 -> 0x00000080.
  - LH addr=0x22 -> 0xFFFF80FF.
  - LHU addr=0x20 -> 0x00007F01.
- Errors, each gives err = 1, rvalid = 0 and leaves memory unchanged (checked by read-back):
  - half store addr=0x21;
  - word load addr=0x22;
  - size=3;
  - addr = DEPTH*4.
- Conflict: word 0x30 = 0. Same cycle: A SH addr=0x30 wdata=0x1111 and B SW addr=0x30 wdata=0xAABBCCDD -> wconflict = 1; read-back = 0xAABB1111.
- Read-during-write: word 0x40 = 0x12345678. Same cycle: A SW addr=0x40 wdata=0x0 and B LW addr=0x40.
  - Without DMEM_WFWD_EN -> b_rdata = 0x12345678.
  - With DMEM_WFWD_EN -> b_rdata = 0x00000000.
- Throughput and reset mid-stream: back-to-back loads on both ports for 8 cycles -> 8 consecutive rvalid pulses per port. Assert rst_n = 0 mid-burst -> rvalid drops to 0 asynchronously.
